// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//
// Watches the four lamp groups of a junction controller and checks that they
// walk through the six legal phases in order and for the legal number of
// cycles.
//
// Phase table (M1, M2, Mt, S), lamp code 100=green 010=yellow 001=red:
//   P1 (100,100,001,001)  dwell TM1+1
//   P2 (100,010,001,001)  dwell TY+1
//   P3 (100,001,100,001)  dwell TMT+1
//   P4 (010,001,010,001)  dwell TY+1
//   P5 (001,001,001,100)  dwell TS+1
//   P6 (001,001,001,010)  dwell TY+1
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   M1, M2, Mt, S observed lamp codes
//   phase         decoded phase of the last sample (0..5), 7 when not in the table
//   locked        high while the monitor is tracking a verified sequence
//   seq_err       one-cycle pulse: phase change to something other than the next phase
//   dur_err       one-cycle pulse: phase left early/late, or stuck past its dwell
//   pattern_err   one-cycle pulse: lamp pattern not in the table
//   conflict_err  one-cycle pulse: conflicting greens/yellows (wins over pattern_err)
//   cycle_cnt     completed legal P6->P1 cycles, wraps at 65536
//   err_cnt       cycles with at least one error pulse, saturates at 255
//
// All outputs are registered: the sample taken at edge k shows after edge k.

module traffic_light_monitor #(
    parameter int TM1 = 7,
    parameter int TY  = 2,
    parameter int TMT = 5,
    parameter int TS  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  M1,
    input  logic [2:0]  M2,
    input  logic [2:0]  Mt,
    input  logic [2:0]  S,
    output logic [2:0]  phase,
    output logic        locked,
    output logic        seq_err,
    output logic        dur_err,
    output logic        pattern_err,
    output logic        conflict_err,
    output logic [15:0] cycle_cnt,
    output logic [7:0]  err_cnt
);

    localparam int          DW     = 16;
    localparam logic [2:0]  PH_BAD = 3'd7;
    localparam logic [2:0]  RED    = 3'b001;

    typedef enum logic {
        SYNC  = 1'b0,
        TRACK = 1'b1
    } state_t;

    // Count limit (legal dwell minus one) of a phase.
    function automatic logic [DW-1:0] limit_of(input logic [2:0] ph);
        logic [DW-1:0] lim;
        case (ph)
            3'd0:                 lim = DW'(TM1);
            3'd1, 3'd3, 3'd5:     lim = DW'(TY);
            3'd2:                 lim = DW'(TMT);
            3'd4:                 lim = DW'(TS);
            default:              lim = '0;
        endcase
        return lim;
    endfunction

    // Registered state
    state_t         r_state;
    logic [2:0]     r_cur;        // last legal phase seen
    logic           r_have_prev;  // r_cur is meaningful (legal sample with no bad one since)
    logic           r_bad_seen;   // previous sample was an unknown pattern
    logic [DW-1:0]  r_dwell;      // samples of r_cur since entering it, minus one
    logic [2:0]     r_phase;
    logic           r_seq;
    logic           r_dur;
    logic           r_pat;
    logic           r_conf;
    logic [15:0]    r_cycle;
    logic [7:0]     r_errc;

    // Combinational next-state
    logic [2:0]     w_dec;
    logic           w_conflict;
    logic [DW-1:0]  w_limit;
    logic [2:0]     w_expect_next;
    state_t         w_state_nx;
    logic [2:0]     w_cur_nx;
    logic           w_have_nx;
    logic           w_bad_nx;
    logic [DW-1:0]  w_dwell_nx;
    logic           w_seq;
    logic           w_dur;
    logic           w_pat;
    logic           w_conf;
    logic           w_cyc_inc;
    logic           w_any_err;

    always_comb begin
        w_dec = PH_BAD;
        case ({M1, M2, Mt, S})
            12'b100_100_001_001: w_dec = 3'd0;
            12'b100_010_001_001: w_dec = 3'd1;
            12'b100_001_100_001: w_dec = 3'd2;
            12'b010_001_010_001: w_dec = 3'd3;
            12'b001_001_001_100: w_dec = 3'd4;
            12'b001_001_001_010: w_dec = 3'd5;
            default:             w_dec = PH_BAD;
        endcase
    end

    // Side street not red while any main/turn lamp is not red, or main-straight
    // and turn both showing go/caution.
    assign w_conflict = ((S != RED) && ((M1 != RED) || (M2 != RED) || (Mt != RED))) ||
                        ((M2 != RED) && (Mt != RED));

    assign w_limit       = limit_of(r_cur);
    assign w_expect_next = (r_cur == 3'd5) ? 3'd0 : r_cur + 3'd1;

    always_comb begin
        w_state_nx = r_state;
        w_cur_nx   = r_cur;
        w_have_nx  = r_have_prev;
        w_bad_nx   = r_bad_seen;
        w_dwell_nx = r_dwell;
        w_seq      = 1'b0;
        w_dur      = 1'b0;
        w_pat      = 1'b0;
        w_conf     = 1'b0;
        w_cyc_inc  = 1'b0;

        if (w_dec == PH_BAD) begin
            // A persisting bad pattern reports once; the next legal phase
            // after it starts synchronisation from scratch.
            w_bad_nx   = 1'b1;
            w_have_nx  = 1'b0;
            w_dwell_nx = '0;
            w_state_nx = SYNC;
            if (!r_bad_seen) begin
                if (w_conflict) w_conf = 1'b1;
                else            w_pat  = 1'b1;
            end
        end else begin
            w_bad_nx = 1'b0;
            if (!r_have_prev) begin
                w_have_nx  = 1'b1;
                w_cur_nx   = w_dec;
                w_dwell_nx = '0;
            end else if (w_dec == r_cur) begin
                if (r_state == TRACK) begin
                    // Reaching limit again means one sample past the legal dwell.
                    if (r_dwell == w_limit) begin
                        w_dur      = 1'b1;
                        w_state_nx = SYNC;
                        w_dwell_nx = '0;
                    end else begin
                        w_dwell_nx = r_dwell + 1'b1;
                    end
                end
            end else begin
                w_cur_nx   = w_dec;
                w_dwell_nx = '0;
                w_state_nx = TRACK;
                if (r_state == TRACK) begin
                    w_seq = (w_dec != w_expect_next);
                    w_dur = (r_dwell != w_limit);
                    if (w_seq || w_dur) w_state_nx = SYNC;
                    else if (r_cur == 3'd5) w_cyc_inc = 1'b1;
                end
            end
        end
    end

    assign w_any_err = w_seq | w_dur | w_pat | w_conf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= SYNC;
            r_cur       <= 3'd0;
            r_have_prev <= 1'b0;
            r_bad_seen  <= 1'b0;
            r_dwell     <= '0;
            r_phase     <= PH_BAD;
            r_seq       <= 1'b0;
            r_dur       <= 1'b0;
            r_pat       <= 1'b0;
            r_conf      <= 1'b0;
            r_cycle     <= '0;
            r_errc      <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_cur       <= w_cur_nx;
            r_have_prev <= w_have_nx;
            r_bad_seen  <= w_bad_nx;
            r_dwell     <= w_dwell_nx;
            r_phase     <= w_dec;
            r_seq       <= w_seq;
            r_dur       <= w_dur;
            r_pat       <= w_pat;
            r_conf      <= w_conf;
            if (w_cyc_inc)
                r_cycle <= r_cycle + 16'd1;
            if (w_any_err && (r_errc != 8'hFF))
                r_errc <= r_errc + 8'd1;
        end
    end

    assign phase        = r_phase;
    assign locked       = (r_state == TRACK);
    assign seq_err      = r_seq;
    assign dur_err      = r_dur;
    assign pattern_err  = r_pat;
    assign conflict_err = r_conf;
    assign cycle_cnt    = r_cycle;
    assign err_cnt      = r_errc;

endmodule

// File: tb/tb_traffic_light_monitor.sv
module tb_traffic_light_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  M1, M2, Mt, S;
    logic [2:0]  phase;
    logic        locked, seq_err, dur_err, pattern_err, conflict_err;
    logic [15:0] cycle_cnt;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    traffic_light_monitor #(.TM1(7), .TY(2), .TMT(5), .TS(4)) dut (
        .clk(clk), .reset(reset), .M1(M1), .M2(M2), .Mt(Mt), .S(S),
        .phase(phase), .locked(locked), .seq_err(seq_err), .dur_err(dur_err),
        .pattern_err(pattern_err), .conflict_err(conflict_err),
        .cycle_cnt(cycle_cnt), .err_cnt(err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [11:0] stim[$];

    // ---------------- reference model ----------------
    int  m_last, m_run, m_cyc, m_errc;
    bit  m_valid, m_bad, m_locked;
    logic [2:0] e_phase;
    logic e_seq, e_dur, e_pat, e_conf;

    function automatic logic [11:0] pat_of(input int p);
        case (p)
            0: return 12'b100_100_001_001;
            1: return 12'b100_010_001_001;
            2: return 12'b100_001_100_001;
            3: return 12'b010_001_010_001;
            4: return 12'b001_001_001_100;
            default: return 12'b001_001_001_010;
        endcase
    endfunction

    function automatic int dwell_of(input int p);
        case (p)
            0: return 8;
            2: return 6;
            4: return 5;
            default: return 3;
        endcase
    endfunction

    function automatic int decode(input logic [11:0] l);
        for (int p = 0; p < 6; p++) if (l == pat_of(p)) return p;
        return 7;
    endfunction

    function automatic bit is_conflict(input logic [11:0] l);
        bit main_not_red = (l[11:9] != 3'b001) || (l[8:6] != 3'b001) || (l[5:3] != 3'b001);
        return ((l[2:0] != 3'b001) && main_not_red) || ((l[8:6] != 3'b001) && (l[5:3] != 3'b001));
    endfunction

    task automatic model_reset();
        m_last = 0; m_run = 0; m_cyc = 0; m_errc = 0;
        m_valid = 0; m_bad = 0; m_locked = 0;
        e_phase = 3'd7; e_seq = 0; e_dur = 0; e_pat = 0; e_conf = 0;
    endtask

    task automatic model_step(input logic [11:0] l);
        int p = decode(l);
        e_phase = 3'(p);
        e_seq = 0; e_dur = 0; e_pat = 0; e_conf = 0;
        if (p == 7) begin
            if (!m_bad) begin
                if (is_conflict(l)) e_conf = 1; else e_pat = 1;
            end
            m_bad = 1; m_valid = 0; m_locked = 0;
        end else begin
            m_bad = 0;
            if (!m_valid) begin
                m_valid = 1; m_last = p; m_run = 1;
            end else if (p == m_last) begin
                m_run++;
                if (m_locked && m_run == dwell_of(p) + 1) begin
                    e_dur = 1; m_locked = 0;
                end
            end else begin
                if (m_locked) begin
                    e_seq = (p != (m_last + 1) % 6);
                    e_dur = (m_run != dwell_of(m_last));
                    if (e_seq || e_dur) m_locked = 0;
                    else if (p == 0) m_cyc = (m_cyc + 1) % 65536;
                end else begin
                    m_locked = 1;
                end
                m_last = p; m_run = 1;
            end
        end
        if ((e_seq || e_dur || e_pat || e_conf) && m_errc < 255) m_errc++;
    endtask

    function automatic logic [31:0] dut_vec();
        return {phase, locked, seq_err, dur_err, pattern_err, conflict_err, cycle_cnt, err_cnt};
    endfunction

    function automatic logic [31:0] exp_vec();
        return {e_phase, logic'(m_locked), e_seq, e_dur, e_pat, e_conf, 16'(m_cyc), 8'(m_errc)};
    endfunction

    task automatic apply(input logic [11:0] l);
        {M1, M2, Mt, S} = l;
        @(posedge clk);
        #1;
        if (reset) model_reset();
        else model_step(l);
    endtask

    task automatic push(input int p, input int n);
        repeat (n) stim.push_back(pat_of(p));
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        apply(pat_of(0));
        apply(pat_of(0));
        n_cmp++;
        if (phase !== 3'd7) begin n_bad++; $display("FAIL reset_phase: got %0d expected 7", phase); end
        n_cmp++;
        if ({locked, seq_err, dur_err, pattern_err, conflict_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b expected 00000",
                              {locked, seq_err, dur_err, pattern_err, conflict_err});
        end
        n_cmp++;
        if ({cycle_cnt, err_cnt} !== 24'd0) begin
            n_bad++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", cycle_cnt, err_cnt);
        end
        reset = 1'b0;
    endtask

    task automatic test_nominal();
        int pulses = 0;
        for (int c = 0; c < 3; c++) for (int p = 0; p < 6; p++) push(p, dwell_of(p));
        for (int i = 0; i < stim.size(); i++) begin
            apply(stim[i]);
            pulses += int'(seq_err) + int'(dur_err) + int'(pattern_err) + int'(conflict_err);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL nominal[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
            if (i == 7 || i == 8) begin
                n_cmp++;
                if (locked !== (i == 8)) begin
                    n_bad++; $display("FAIL nominal_lock[%0d]: got %b expected %b", i, locked, i == 8);
                end
            end
        end
        stim.delete();
        n_cmp++;
        if (pulses != 0) begin n_bad++; $display("FAIL nominal_pulses: got %0d expected 0", pulses); end
        n_cmp++;
        if (cycle_cnt !== 16'd2 || locked !== 1'b1) begin
            n_bad++; $display("FAIL nominal_end: got cyc=%0d lock=%b expected cyc=2 lock=1", cycle_cnt, locked);
        end
    endtask

    task automatic test_short_p3();
        int durs = 0;
        push(0, 8); push(1, 3); push(2, 5); push(3, 3); push(4, 5);
        for (int i = 0; i < stim.size(); i++) begin
            apply(stim[i]);
            durs += int'(dur_err);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL short_p3[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
            if (i == 16) begin
                n_cmp++;
                if ({dur_err, locked, err_cnt} !== {1'b1, 1'b0, 8'd1}) begin
                    n_bad++; $display("FAIL short_p3_hit: got dur=%b lock=%b err=%0d expected 1/0/1",
                                      dur_err, locked, err_cnt);
                end
            end
        end
        stim.delete();
        n_cmp++;
        if (durs != 1 || locked !== 1'b1 || err_cnt !== 8'd1) begin
            n_bad++; $display("FAIL short_p3_end: got durs=%0d lock=%b err=%0d expected 1/1/1", durs, locked, err_cnt);
        end
    endtask

    task automatic test_seq_jump();
        int seqs = 0;
        logic [7:0] err0 = err_cnt;
        push(5, 3); push(0, 8); push(1, 3); push(3, 3);
        for (int i = 0; i < stim.size(); i++) begin
            apply(stim[i]);
            seqs += int'(seq_err);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL seq_jump[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
            if (i == 14) begin
                n_cmp++;
                if ({seq_err, dur_err, locked} !== 3'b100 || err_cnt !== err0 + 8'd1) begin
                    n_bad++; $display("FAIL seq_jump_hit: got s/d/l=%b%b%b err=%0d expected 100 err=%0d",
                                      seq_err, dur_err, locked, err_cnt, err0 + 8'd1);
                end
            end
        end
        stim.delete();
        n_cmp++;
        if (seqs != 1) begin n_bad++; $display("FAIL seq_jump_count: got %0d expected 1", seqs); end
    endtask

    task automatic test_conflict();
        int confs = 0, pats = 0, sevens = 0;
        repeat (4) stim.push_back(12'b100_100_100_001);
        push(4, 1);
        for (int i = 0; i < stim.size(); i++) begin
            apply(stim[i]);
            confs += int'(conflict_err);
            pats  += int'(pattern_err);
            if (i < 4) sevens += int'(phase == 3'd7);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL conflict[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        stim.delete();
        n_cmp++;
        if (confs != 1 || pats != 0 || sevens != 4) begin
            n_bad++; $display("FAIL conflict_summary: got conf=%0d pat=%0d p7=%0d expected 1/0/4", confs, pats, sevens);
        end
    endtask

    task automatic test_stuck_p1();
        int errs = 0;
        push(4, 4); push(5, 3); push(0, 9); push(1, 3);
        for (int i = 0; i < stim.size(); i++) begin
            apply(stim[i]);
            errs += int'(seq_err) + int'(dur_err);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL stuck_p1[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
            if (i == 15) begin
                n_cmp++;
                if ({dur_err, locked} !== 2'b10) begin
                    n_bad++; $display("FAIL stuck_p1_hit: got dur=%b lock=%b expected 1/0", dur_err, locked);
                end
            end
        end
        stim.delete();
        n_cmp++;
        if (errs != 1 || locked !== 1'b1) begin
            n_bad++; $display("FAIL stuck_p1_end: got errs=%0d lock=%b expected 1/1", errs, locked);
        end
    endtask

    task automatic test_random();
        int ph = 0;
        for (int seg = 0; seg < 70; seg++) begin
            int r = int'($urandom_range(0, 11));
            if (r == 0) begin
                repeat ($urandom_range(1, 3)) stim.push_back(12'($urandom));
            end else begin
                int d;
                ph = (r == 1) ? int'($urandom_range(0, 5)) : (ph + 1) % 6;
                d  = dwell_of(ph);
                if (r == 2) d = d - 1 + int'($urandom_range(0, 2));
                if (r == 3) d = d + 2;
                if (d < 1) d = 1;
                push(ph, d);
            end
        end
        for (int i = 0; i < stim.size(); i++) begin
            apply(stim[i]);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL random[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        stim.delete();
    endtask

    task automatic test_sat_reset();
        for (int k = 0; k < 262; k++) begin
            push(0, 1);
            stim.push_back(12'b001_001_001_001);
        end
        push(3, 3); push(4, 2);
        for (int i = 0; i < stim.size(); i++) begin
            apply(stim[i]);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL saturate[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        stim.delete();
        n_cmp++;
        if (err_cnt !== 8'd255) begin n_bad++; $display("FAIL saturate_hold: got %0d expected 255", err_cnt); end
        reset = 1'b1;
        apply(pat_of(4));
        reset = 1'b0;
        n_cmp++;
        if ({phase, locked, seq_err, dur_err, pattern_err, conflict_err, cycle_cnt, err_cnt} !==
            {3'd7, 5'b0, 16'd0, 8'd0}) begin
            n_bad++; $display("FAIL midp5_reset: got %h expected %h", dut_vec(), {3'd7, 5'b0, 24'd0});
        end
        push(4, 2); push(5, 3); push(0, 2);
        for (int i = 0; i < stim.size(); i++) begin
            apply(stim[i]);
            n_cmp++;
            if (dut_vec() !== exp_vec()) begin
                n_bad++; $display("FAIL resync[%0d]: got %h expected %h", i, dut_vec(), exp_vec());
            end
        end
        stim.delete();
        n_cmp++;
        if (locked !== 1'b1 || err_cnt !== 8'd0 || cycle_cnt !== 16'd1) begin
            n_bad++; $display("FAIL resync_end: got lock=%b err=%0d cyc=%0d expected 1/0/1", locked, err_cnt, cycle_cnt);
        end
    endtask

    initial begin
        reset = 1'b1;
        {M1, M2, Mt, S} = pat_of(0);
        model_reset();
        test_reset();
        test_nominal();
        test_short_p3();
        test_seq_jump();
        test_conflict();
        test_stuck_p1();
        test_random();
        test_sat_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter TM1, default 7: main-green count limit; the legal dwell of P1 is TM1+1 cycles.
REQ-002 Parameter TY, default 2: yellow count limit; the legal dwell of P2, P4 and P6 is TY+1 cycles.
REQ-003 Parameter TMT, default 5: turn-green count limit; the legal dwell of P3 is TMT+1 cycles.
REQ-004 Parameter TS, default 4: side-green count limit; the legal dwell of P5 is TS+1 cycles.
REQ-005 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-006 Port reset  input  1: synchronous, active-high reset.
REQ-007 Ports M1, M2, Mt, S  input  3 each: observed lamp codes, where 100=green, 010=yellow, 001=red.
REQ-008 Port phase  output  3: decoded phase, 0..5 for P1..P6, and 7 for a pattern not in the table.
REQ-009 Port locked  output  1: high while the FSM is in TRACK.
REQ-010 Ports seq_err, dur_err, pattern_err, conflict_err  output  1 each: one-cycle error pulses.
REQ-011 Port cycle_cnt  output  16: count of completed legal signal cycles.
REQ-012 Port err_cnt  output  8: count of error events.

Function
REQ-013 Decode table (M1,M2,Mt,S) SHALL be:
- P1 = (100,100,001,001)
- P2 = (100,010,001,001)
- P3 = (100,001,100,001)
- P4 = (010,001,010,001)
- P5 = (001,001,001,100)
- P6 = (001,001,001,010)
REQ-014 Conflict SHALL be detected when either condition holds:
- S is not 001 while any of M1, M2 or Mt is not 001;
- M2 is not 001 while Mt is not 001.
REQ-015 Any other pattern not in the table, including lamp codes that are not one-hot, SHALL be classed as a pattern error.
REQ-016 All outputs SHALL be registered; the decode of the inputs sampled at edge k SHALL appear on the outputs after edge k.
REQ-017 FSM states SHALL be SYNC and TRACK; reset enters SYNC.
REQ-018 In SYNC, the first change from one legal phase to a different legal phase SHALL enter TRACK and clear the dwell counter.
- No seq_err or dur_err is raised for this first change.
REQ-019 In TRACK, the dwell counter SHALL increment on every cycle the sampled phase equals the current phase.
REQ-020 In TRACK, on a change to a new legal phase:
- the new phase SHALL equal (old+1) mod 6, else seq_err;
- the dwell SHALL equal the legal dwell of the old phase, else dur_err.
REQ-021 In TRACK, when the dwell reaches the legal dwell + 1 without a change (stuck phase), dur_err SHALL pulse once.
REQ-022 Any error in TRACK SHALL return the FSM to SYNC and clear the dwell counter.
REQ-023 A conflict SHALL pulse conflict_err in either state; any other unknown pattern SHALL pulse pattern_err in either state.
- conflict_err has priority; only one of the two pulses per cycle.
- phase shows 7 for both.
REQ-024 A legal P6->P1 transition in TRACK with no error SHALL increment cycle_cnt, wrapping from 65535 to 0.
REQ-025 err_cnt SHALL increment by exactly 1 in any cycle where one or more error pulses assert, and SHALL saturate at 255.
REQ-026 Error pulses SHALL last exactly one cycle; an error condition that persists SHALL not re-pulse.
- Exception: pattern_err and conflict_err re-pulse only after a legal pattern has been seen.

Reset
REQ-027 When reset is high at a clock edge, the block SHALL set:
- phase=7, locked=0, all error pulses=0;
- cycle_cnt=0, err_cnt=0, dwell=0;
- FSM=SYNC.
REQ-028 Reset asserted mid-phase or mid-error SHALL override all other updates in that cycle.
REQ-029 After reset, the block SHALL resynchronise per REQ-018.

Verification
REQ-030 Bench SHALL drive the nominal sequence with default dwells (8, 3, 6, 3, 5, 3) for 3 cycles -> locked after the first transition, no error pulses, cycle_cnt=2 (the first P6->P1 is seen before lock or counted per REQ-024).
REQ-031 Bench SHALL hold P3 for 5 cycles instead of 6 while locked -> single dur_err, locked=0, err_cnt=1, then relock at the next transition.
REQ-032 Bench SHALL jump P2->P4 while locked -> seq_err for one cycle, locked drops, err_cnt increments by 1.
REQ-033 Bench SHALL drive M2=100 with Mt=100 for 4 cycles -> one conflict_err pulse, phase=7 for 4 cycles, no pattern_err.
REQ-034 Bench SHALL hold P1 for 9 cycles while locked -> dur_err on the 9th sampled cycle; the later P1->P2 change raises no further error.
REQ-035 Bench SHALL assert reset for 1 cycle mid-P5 with err_cnt=255 -> all counters and outputs at reset values, and err_cnt saturation was held at 255 before the reset.
